// File: rtl/clcd_pkg.sv
// Shared definitions for the HD44780 / PCF8574 character writer.
// Holds the PCF8574 frame bit positions, the init command constants, the DDRAM
// row-base table and the top-level state enum.
// Optional build macro: CLCD_AUTO_WRAP_EN adds the S_WRAP state.
package clcd_pkg;

  // PCF8574 low-nibble bit positions; D7..D4 occupy bits 7..4
  localparam int unsigned BIT_BL = 3;
  localparam int unsigned BIT_E  = 2;
  localparam int unsigned BIT_RW = 1;
  localparam int unsigned BIT_RS = 0;

  // Power-on nibbles: three 8-bit wake-ups, then the switch to 4-bit mode
  localparam logic [3:0] INIT_WAKE_NIB  = 4'h3;
  localparam logic [3:0] INIT_4BIT_NIB  = 4'h2;
  localparam int unsigned INIT_NIB_CNT  = 4;
  localparam int unsigned INIT_STEPS    = 12;  // 4 lone nibbles + 4 bytes * 2

  localparam logic [7:0] CMD_FUNCTION_SET = 8'h28;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
  localparam logic [7:0] CMD_HOME         = 8'h02;
  localparam logic [7:0] CMD_SET_DDRAM    = 8'h80;

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_INIT,
    S_IDLE,
    S_XFER
`ifdef CLCD_AUTO_WRAP_EN
    , S_WRAP
`endif
  } state_t;

  // DDRAM address of column 0 for each row
  function automatic logic [7:0] row_base(input logic [1:0] row);
    case (row)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNCTION_SET;
      2'd1:    return CMD_DISPLAY_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY_MODE;
    endcase
  endfunction

  // Nibble for init step 0..11; byte steps alternate high then low nibble
  function automatic logic [3:0] init_nibble(input logic [3:0] step);
    logic [7:0] b;
    if (step < 4'(INIT_NIB_CNT))
      return (step == 4'(INIT_NIB_CNT - 1)) ? INIT_4BIT_NIB : INIT_WAKE_NIB;
    b = init_byte(2'((step - 4'(INIT_NIB_CNT)) >> 1));
    return step[0] ? b[3:0] : b[7:4];
  endfunction

  function automatic logic [7:0] lcd_frame(input logic [3:0] nib, input logic bl,
                                           input logic e, input logic rs);
    logic [7:0] f;
    f         = '0;
    f[7:4]    = nib;
    f[BIT_BL] = bl;
    f[BIT_E]  = e;
    f[BIT_RW] = 1'b0;
    f[BIT_RS] = rs;
    return f;
  endfunction

endpackage

// File: rtl/clcd_nibble_sender.sv
// Sends one nibble as two PCF8574 frames (E high, then E low) to the I2C master.
// Each frame is held valid until busy rises, then the sender waits for busy to
// fall and a further SETTLE_US before the next frame or done.
// Ports: clk, reset_p (async, active-high), start/nibble/rs request,
//        busy from the I2C master, frame/frame_valid to the master, done pulse.
module clcd_nibble_sender
  import clcd_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SETTLE_US = 1000,
  parameter logic        BACKLIGHT = 1'b1
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       start,
  input  logic [3:0] nibble,
  input  logic       rs,
  input  logic       busy,
  output logic [7:0] frame,
  output logic       frame_valid,
  output logic       done
);

  localparam int unsigned CYC_PER_US = (CLK_HZ >= 1_000_000) ? CLK_HZ / 1_000_000 : 1;
  localparam int unsigned SETTLE_CYC = (SETTLE_US * CYC_PER_US > 0) ? SETTLE_US * CYC_PER_US : 1;
  localparam int unsigned CNT_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {N_IDLE, N_FRAME, N_FALL, N_SETTLE} nstate_t;

  nstate_t          state_q, state_d;
  logic             busy_q;
  logic [3:0]       nib_q, nib_d;
  logic             rs_q, rs_d;
  logic             second_q, second_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       frame_d;
  logic             frame_valid_d, done_d;
  logic             busy_rise_c, busy_fall_c;

  assign busy_rise_c = busy & ~busy_q;
  assign busy_fall_c = ~busy & busy_q;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q     <= N_IDLE;
      busy_q      <= 1'b0;
      nib_q       <= '0;
      rs_q        <= 1'b0;
      second_q    <= 1'b0;
      cnt_q       <= '0;
      frame       <= 8'h00;
      frame_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy;
      nib_q       <= nib_d;
      rs_q        <= rs_d;
      second_q    <= second_d;
      cnt_q       <= cnt_d;
      frame       <= frame_d;
      frame_valid <= frame_valid_d;
      done        <= done_d;
    end
  end

  // Frame sequencing; settle is counted in clk cycles from the detected busy fall
  always_comb begin
    state_d       = state_q;
    nib_d         = nib_q;
    rs_d          = rs_q;
    second_d      = second_q;
    cnt_d         = cnt_q;
    frame_d       = frame;
    frame_valid_d = frame_valid;
    done_d        = 1'b0;
    case (state_q)
      N_IDLE: begin
        if (start) begin
          nib_d         = nibble;
          rs_d          = rs;
          second_d      = 1'b0;
          frame_d       = lcd_frame(nibble, BACKLIGHT, 1'b1, rs);
          frame_valid_d = 1'b1;
          state_d       = N_FRAME;
        end
      end
      N_FRAME: begin
        if (busy_rise_c) begin
          frame_valid_d = 1'b0;
          state_d       = N_FALL;
        end
      end
      N_FALL: begin
        if (busy_fall_c) begin
          cnt_d   = '0;
          state_d = N_SETTLE;
        end
      end
      N_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          if (!second_q) begin
            second_d      = 1'b1;
            frame_d       = lcd_frame(nib_q, BACKLIGHT, 1'b0, rs_q);
            frame_valid_d = 1'b1;
            state_d       = N_FRAME;
          end else begin
            done_d  = 1'b1;
            state_d = N_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = N_IDLE;
    endcase
  end

endmodule

// File: rtl/clcd_i2c_char_writer.sv
// HD44780 character writer over a PCF8574 I2C backpack in 4-bit mode.
// Runs the power-on init, then accepts characters/commands over valid/ready,
// sends each as four frames and tracks the cursor position.
// Build macro: CLCD_AUTO_WRAP_EN re-addresses DDRAM on every line wrap.
// Ports: clk, reset_p (async, active-high); i_char/i_rs/i_valid/o_ready request
//        handshake; i_busy, o_addr, o_data, o_rw, o_valid to the I2C master;
//        o_init_done, o_col, o_row status.
module clcd_i2c_char_writer
  import clcd_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter logic [6:0]  I2C_ADDR     = 7'h27,
  parameter int unsigned INIT_WAIT_MS = 40,
  parameter int unsigned SETTLE_US    = 1000,
  parameter int unsigned COLS         = 16,
  parameter int unsigned ROWS         = 2,
  parameter int unsigned BACKLIGHT    = 1
) (
  input  logic                                       clk,
  input  logic                                       reset_p,
  input  logic [7:0]                                 i_char,
  input  logic                                       i_rs,
  input  logic                                       i_valid,
  output logic                                       o_ready,
  input  logic                                       i_busy,
  output logic [6:0]                                 o_addr,
  output logic [7:0]                                 o_data,
  output logic                                       o_rw,
  output logic                                       o_valid,
  output logic                                       o_init_done,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] o_col,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] o_row
);

  localparam int unsigned COL_W      = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CYC_PER_US = (CLK_HZ >= 1_000_000) ? CLK_HZ / 1_000_000 : 1;
  localparam int unsigned DIV_W      = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
  localparam int unsigned WAIT_TICKS = (INIT_WAIT_MS * 1000 > 0) ? INIT_WAIT_MS * 1000 : 1;
  localparam int unsigned WAIT_W     = (WAIT_TICKS > 1) ? $clog2(WAIT_TICKS) : 1;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        step_q, step_d;
  logic              launched_q, launched_d;
  logic [7:0]        char_q, char_d;
  logic              rs_q, rs_d;
  logic [COL_W-1:0]  col_d;
  logic [ROW_W-1:0]  row_d;
  logic              ready_d, init_done_d;
  logic              tick_c, start_c, sending_c, last_c, seq_done_c;
  logic [3:0]        nib_c;
  logic              nrs_c;
  logic              nib_done;
`ifdef CLCD_AUTO_WRAP_EN
  logic [7:0]        wrap_cmd_c;
`endif

  assign o_addr = I2C_ADDR;
  assign o_rw   = 1'b0;
  assign tick_c = (div_q == DIV_W'(CYC_PER_US - 1));

  // Free-running 1 us tick divider
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)     div_q <= '0;
    else if (tick_c) div_q <= '0;
    else             div_q <= div_q + DIV_W'(1);
  end

  clcd_nibble_sender #(
    .CLK_HZ   (CLK_HZ),
    .SETTLE_US(SETTLE_US),
    .BACKLIGHT(BACKLIGHT != 0)
  ) u_sender (
    .clk        (clk),
    .reset_p    (reset_p),
    .start      (start_c),
    .nibble     (nib_c),
    .rs         (nrs_c),
    .busy       (i_busy),
    .frame      (o_data),
    .frame_valid(o_valid),
    .done       (nib_done)
  );

  // Which nibble the current state sends, and whether it is the state's last
  always_comb begin
    nib_c     = '0;
    nrs_c     = 1'b0;
    last_c    = 1'b0;
    sending_c = 1'b0;
`ifdef CLCD_AUTO_WRAP_EN
    wrap_cmd_c = CMD_SET_DDRAM | row_base(2'(o_row));
`endif
    case (state_q)
      S_INIT: begin
        nib_c     = init_nibble(step_q);
        last_c    = (step_q == 4'(INIT_STEPS - 1));
        sending_c = 1'b1;
      end
      S_XFER: begin
        nib_c     = step_q[0] ? char_q[3:0] : char_q[7:4];
        nrs_c     = rs_q;
        last_c    = step_q[0];
        sending_c = 1'b1;
      end
`ifdef CLCD_AUTO_WRAP_EN
      S_WRAP: begin
        nib_c     = step_q[0] ? wrap_cmd_c[3:0] : wrap_cmd_c[7:4];
        last_c    = step_q[0];
        sending_c = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign seq_done_c = sending_c & launched_q & nib_done & last_c;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q     <= S_PWR_WAIT;
      wait_q      <= '0;
      step_q      <= '0;
      launched_q  <= 1'b0;
      char_q      <= 8'h00;
      rs_q        <= 1'b0;
      o_col       <= '0;
      o_row       <= '0;
      o_ready     <= 1'b0;
      o_init_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      step_q      <= step_d;
      launched_q  <= launched_d;
      char_q      <= char_d;
      rs_q        <= rs_d;
      o_col       <= col_d;
      o_row       <= row_d;
      o_ready     <= ready_d;
      o_init_done <= init_done_d;
    end
  end

  // Next state, nibble launching and cursor tracking
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    step_d      = step_q;
    launched_d  = launched_q;
    char_d      = char_q;
    rs_d        = rs_q;
    col_d       = o_col;
    row_d       = o_row;
    ready_d     = o_ready;
    init_done_d = o_init_done;
    start_c     = 1'b0;

    // One nibble in flight at a time: launch, then advance on done
    if (sending_c) begin
      if (!launched_q) begin
        start_c    = 1'b1;
        launched_d = 1'b1;
      end else if (nib_done) begin
        launched_d = 1'b0;
        step_d     = step_q + 4'd1;
      end
    end

    case (state_q)
      S_PWR_WAIT: begin
        if (tick_c) begin
          if (wait_q == WAIT_W'(WAIT_TICKS - 1)) begin
            state_d    = S_INIT;
            step_d     = '0;
            launched_d = 1'b0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      S_INIT: begin
        if (seq_done_c) begin
          state_d     = S_IDLE;
          ready_d     = 1'b1;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (i_valid && o_ready) begin
          char_d     = i_char;
          rs_d       = i_rs;
          ready_d    = 1'b0;
          step_d     = '0;
          launched_d = 1'b0;
          state_d    = S_XFER;
        end
      end
      S_XFER: begin
        if (seq_done_c) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          if (rs_q) begin
            if (o_col == COL_W'(COLS - 1)) begin
              col_d = '0;
              row_d = (o_row == ROW_W'(ROWS - 1)) ? '0 : o_row + ROW_W'(1);
`ifdef CLCD_AUTO_WRAP_EN
              state_d    = S_WRAP;
              ready_d    = 1'b0;
              step_d     = '0;
              launched_d = 1'b0;
`endif
            end else begin
              col_d = o_col + COL_W'(1);
            end
          end else if (char_q == CMD_CLEAR || char_q == CMD_HOME) begin
            col_d = '0;
            row_d = '0;
          end
        end
      end
`ifdef CLCD_AUTO_WRAP_EN
      S_WRAP: begin
        if (seq_done_c) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
`endif
      default: state_d = S_PWR_WAIT;
    endcase
  end

endmodule

// File: tb/tb_clcd_i2c_char_writer.sv
// Scoreboard bench for clcd_i2c_char_writer with a reduced clock/time base.
`timescale 1ns/1ps
module tb_clcd_i2c_char_writer;

  localparam int unsigned CLK_HZ       = 2_000_000;   // 500 ns period
  localparam int unsigned INIT_WAIT_MS = 1;
  localparam int unsigned SETTLE_US    = 10;
  localparam int unsigned COLS         = 16;
  localparam int unsigned ROWS         = 2;
  localparam int unsigned BACKLIGHT    = 1;
  localparam int unsigned READY_BOUND  = 8000;
`ifdef CLCD_AUTO_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_p;
  logic [7:0] i_char;
  logic       i_rs;
  logic       i_valid;
  logic       o_ready;
  logic       i_busy;
  logic [6:0] o_addr;
  logic [7:0] o_data;
  logic       o_rw;
  logic       o_valid;
  logic       o_init_done;
  logic [3:0] o_col;
  logic [0:0] o_row;

  always #250 clk = ~clk;

  clcd_i2c_char_writer #(
    .CLK_HZ(CLK_HZ), .I2C_ADDR(7'h27), .INIT_WAIT_MS(INIT_WAIT_MS),
    .SETTLE_US(SETTLE_US), .COLS(COLS), .ROWS(ROWS), .BACKLIGHT(BACKLIGHT)
  ) dut (
    .clk(clk), .reset_p(reset_p), .i_char(i_char), .i_rs(i_rs),
    .i_valid(i_valid), .o_ready(o_ready), .i_busy(i_busy), .o_addr(o_addr),
    .o_data(o_data), .o_rw(o_rw), .o_valid(o_valid),
    .o_init_done(o_init_done), .o_col(o_col), .o_row(o_row)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] fq[$];          // expected frames in order
  logic [5:0] cq[$];          // expected {init_done,row,col} at each ready rise
  int         m_col, m_row;
  bit         first_frame;
  bit         long_next = 1'b0;
  time        t_rise, t_fall, t_rel;

  always @(posedge o_valid) t_rise = $time;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_frame(input logic [3:0] nib, input bit e, input bit rs);
    return {nib, 1'(BACKLIGHT), e, 1'b0, rs};
  endfunction

  task automatic push_nib(input logic [3:0] nib, input bit rs);
    fq.push_back(ref_frame(nib, 1'b1, rs));
    fq.push_back(ref_frame(nib, 1'b0, rs));
  endtask

  task automatic push_byte(input logic [7:0] b, input bit rs);
    push_nib(b[7:4], rs);
    push_nib(b[3:0], rs);
  endtask

  function automatic logic [5:0] cursor(input int c, input int r);
    return {1'b1, 1'(r), 4'(c)};
  endfunction

  task automatic model_init();
    m_col = 0;
    m_row = 0;
    push_nib(4'h3, 1'b0); push_nib(4'h3, 1'b0); push_nib(4'h3, 1'b0); push_nib(4'h2, 1'b0);
    push_byte(8'h28, 1'b0); push_byte(8'h0C, 1'b0); push_byte(8'h01, 1'b0); push_byte(8'h06, 1'b0);
    cq.push_back(cursor(0, 0));
  endtask

  task automatic model_req(input logic [7:0] b, input bit rs);
    int bases[4];
    bases = '{8'h00, 8'h40, 8'h14, 8'h54};
    push_byte(b, rs);
    if (rs) begin
      m_col++;
      if (m_col == int'(COLS)) begin
        m_col = 0;
        m_row = (m_row + 1) % int'(ROWS);
        if (WRAP_EN) push_byte(8'h80 | 8'(bases[m_row]), 1'b0);
      end
    end else if (b == 8'h01 || b == 8'h02) begin
      m_col = 0;
      m_row = 0;
    end
    cq.push_back(cursor(m_col, m_row));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready();
    int n = 0;
    while (o_ready !== 1'b1 && n < int'(READY_BOUND)) begin
      @(negedge clk);
      n++;
    end
    if (o_ready !== 1'b1) fail_now("ready_timeout");
  endtask

  task automatic send(input logic [7:0] b, input bit rs);
    int n = 0;
    model_req(b, rs);
    @(negedge clk);
    i_char  = b;
    i_rs    = rs;
    i_valid = 1'b1;
    while (o_ready !== 1'b1 && n < int'(READY_BOUND)) begin
      @(negedge clk);
      n++;
    end
    if (o_ready !== 1'b1) fail_now("accept_timeout");
    @(negedge clk);
    i_valid = 1'b0;
    i_char  = 8'($urandom);
    i_rs    = 1'($urandom);
  endtask

  task automatic send_rand_data(input int count);
    for (int k = 0; k < count; k++) send(8'($urandom_range(32, 126)), 1'b1);
  endtask

  // ---------------- I2C master model + frame monitor ----------------
  initial begin
    int d;
    bit held, lng;
    i_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        if (fq.size() == 0) fail_now("unexpected_frame");
        else check("frame", 64'(o_data), 64'(fq.pop_front()));
        check("addr_rw", 64'({o_addr, o_rw}), 64'({7'h27, 1'b0}));
        if (first_frame) begin
          check("power_wait", 64'((t_rise - t_rel) >= 64'(INIT_WAIT_MS) * 64'd1_000_000), 64'd1);
          first_frame = 1'b0;
        end else begin
          check("settle_gap", 64'((t_rise - t_fall) >= 64'(SETTLE_US) * 64'd1000), 64'd1);
        end
        lng       = long_next;
        long_next = 1'b0;
        d         = lng ? 50 : 5;
        held      = 1'b1;
        repeat (d) begin
          @(negedge clk);
          if (o_valid !== 1'b1) held = 1'b0;
        end
        if (lng) check("valid_held_no_busy", 64'(held), 64'd1);
        i_busy = 1'b1;
        @(negedge clk);
        check("valid_drop_after_busy", 64'(o_valid), 64'd0);
        repeat (19) @(negedge clk);
        i_busy = 1'b0;
        t_fall = $time;
      end
    end
  end

  // ---------------- cursor / status monitor ----------------
  initial begin
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_ready === 1'b1 && !prev) begin
        if (cq.size() == 0) fail_now("unexpected_ready");
        else check("cursor", 64'({o_init_done, o_row, o_col}), 64'(cq.pop_front()));
      end
      prev = (o_ready === 1'b1);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    repeat (90_000) @(posedge clk);
    fail_now("watchdog");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- main stimulus ----------------
  initial begin
    int n;
    reset_p     = 1'b1;
    i_valid     = 1'b0;
    i_char      = 8'h00;
    i_rs        = 1'b0;
    first_frame = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_data", 64'(o_data), 64'h00);
    check("reset_ready", 64'(o_ready), 64'd0);
    check("reset_init_done", 64'(o_init_done), 64'd0);
    check("reset_cursor", 64'({o_row, o_col}), 64'd0);

    reset_p = 1'b0;
    t_rel   = $time;
    model_init();
    wait_ready();

    send(8'h41, 1'b1);                     // 'A' -> 4D 49 1D 19
    wait_ready();
    long_next = 1'b1;                      // next frame: busy delayed 50 cycles
    send_rand_data(1);
    send_rand_data(14);                    // 16th data write wraps to row 1
    send(8'hC5, 1'b0);                     // user set-DDRAM: cursor unchanged
    send(8'h0E, 1'b0);
    send_rand_data(16);                    // 32nd data write wraps back to row 0
    send_rand_data(5);
    send(8'h01, 1'b0);                     // clear
    send_rand_data(3);
    send(8'h02, 1'b0);                     // home
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 3) == 0) send(8'h10, 1'b0);
      else send_rand_data(1);
    end
    wait_ready();

    // Reset in the middle of a frame
    send(8'h52, 1'b1);
    n = 0;
    while (o_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (o_valid !== 1'b1) fail_now("frame_before_reset_timeout");
    @(negedge clk);
    reset_p = 1'b1;
    #1;
    check("midreset_valid", 64'(o_valid), 64'd0);
    check("midreset_init_done", 64'(o_init_done), 64'd0);
    check("midreset_ready", 64'(o_ready), 64'd0);
    fq.delete();
    cq.delete();
    repeat (3) @(negedge clk);
    first_frame = 1'b1;
    reset_p     = 1'b0;
    t_rel       = $time;
    model_init();
    wait_ready();
    send(8'h5A, 1'b1);
    wait_ready();
    repeat (3) @(negedge clk);
    check("leftover_expectations", 64'(fq.size() + cq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
